// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter (rev 1.0): shares one MMU request/response port between instruction fetch and
// load/store, with one pending slot per requester, round-robin grant, fetch squash and response timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_request_enable,
    input  logic        freq_mode,
    input  logic [31:0] freq_addr,
    input  logic [31:0] freq_wdata,
    input  logic [3:0]  freq_wstrb,
    input  logic        fetch_flush,
    output logic        fetch_response_enable,
    output logic [31:0] fresp_data,
    input  logic        mem_request_enable,
    input  logic        mreq_mode,
    input  logic [31:0] mreq_addr,
    input  logic [31:0] mreq_wdata,
    input  logic [3:0]  mreq_wstrb,
    output logic        mem_response_enable,
    output logic [31:0] mresp_data,
    output logic        request_enable,
    output logic        req_mode,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        response_enable,
    input  logic [31:0] resp_data,
    output logic        resp_error,
    output logic        protocol_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        RESPOND   = 2'd2
    } state_t;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    req_t             f_slot;
    req_t             m_slot;
    req_t             f_in;
    req_t             m_in;
    req_t             cur_req;
    logic             f_valid;
    logic             m_valid;
    logic             cur_fetch;
    logic             squashed;
    logic             last_grant_mem;
    logic             timed_out;
    logic [CNT_W-1:0] tmo_cnt;
    logic [31:0]      resp_buf;

    logic             idle;
    logic             fetch_busy;
    logic             mem_busy;
    logic             fetch_acc;
    logic             mem_acc;
    logic             fetch_cand;
    logic             mem_cand;
    logic             grant_fetch;
    logic             grant_mem;
    logic             timeout_hit;

    assign f_in = {freq_mode, freq_addr, freq_wdata, freq_wstrb};
    assign m_in = {mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb};
    assign idle = (state == IDLE);

    // A squashed fetch still occupies the port but no longer blocks a new fetch request;
    // a flush always makes room for a same-cycle fetch request.
    assign fetch_busy = f_valid | (~idle & cur_fetch & ~squashed);
    assign mem_busy   = m_valid | (~idle & ~cur_fetch);
    assign fetch_acc  = fetch_request_enable & (fetch_flush | ~fetch_busy);
    assign mem_acc    = mem_request_enable & ~mem_busy;

    assign fetch_cand  = idle & (fetch_acc | (f_valid & ~fetch_flush));
    assign mem_cand    = idle & (mem_acc | m_valid);
    assign grant_fetch = fetch_cand & (~mem_cand | last_grant_mem);
    assign grant_mem   = mem_cand & (~fetch_cand | ~last_grant_mem);

    assign timeout_hit = (state == WAIT_RESP) & ~response_enable & (tmo_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_fetch || grant_mem) state_nxt = WAIT_RESP;
            WAIT_RESP: if (response_enable || timeout_hit) state_nxt = RESPOND;
            RESPOND:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            f_valid        <= 1'b0;
            m_valid        <= 1'b0;
            f_slot         <= '0;
            m_slot         <= '0;
            cur_req        <= '0;
            cur_fetch      <= 1'b0;
            squashed       <= 1'b0;
            last_grant_mem <= 1'b1;
            timed_out      <= 1'b0;
            tmo_cnt        <= '0;
            resp_buf       <= '0;
            request_enable <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            request_enable <= grant_fetch | grant_mem;
            protocol_error <= protocol_error | (fetch_request_enable & ~fetch_acc)
                                             | (mem_request_enable & ~mem_acc);

            if (grant_fetch) begin
                cur_req        <= fetch_acc ? f_in : f_slot;
                cur_fetch      <= 1'b1;
                squashed       <= 1'b0;
                last_grant_mem <= 1'b0;
            end else if (grant_mem) begin
                cur_req        <= mem_acc ? m_in : m_slot;
                cur_fetch      <= 1'b0;
                squashed       <= 1'b0;
                last_grant_mem <= 1'b1;
            end else if (fetch_flush && !idle && cur_fetch) begin
                squashed <= 1'b1;
            end

            if (grant_fetch) begin
                f_valid <= 1'b0;
            end else if (fetch_acc) begin
                f_valid <= 1'b1;
                f_slot  <= f_in;
            end else if (fetch_flush) begin
                f_valid <= 1'b0;
            end

            if (grant_mem) begin
                m_valid <= 1'b0;
            end else if (mem_acc) begin
                m_valid <= 1'b1;
                m_slot  <= m_in;
            end

            tmo_cnt <= (state == WAIT_RESP) ? tmo_cnt + 1'b1 : '0;

            if (state == WAIT_RESP && response_enable) begin
                resp_buf  <= resp_data;
                timed_out <= 1'b0;
            end else if (timeout_hit) begin
                resp_buf  <= '0;
                timed_out <= 1'b1;
            end
        end
    end

    assign fetch_response_enable = (state == RESPOND) & cur_fetch & ~squashed;
    assign mem_response_enable   = (state == RESPOND) & ~cur_fetch;
    assign fresp_data            = fetch_response_enable ? resp_buf : 32'h0;
    assign mresp_data            = mem_response_enable ? resp_buf : 32'h0;
    assign resp_error            = timed_out & (fetch_response_enable | mem_response_enable);
    assign busy                  = ~idle;

    assign req_mode  = cur_req.mode;
    assign req_addr  = cur_req.addr;
    assign req_wdata = cur_req.wdata;
    assign req_wstrb = cur_req.wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed scenarios plus a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_request_enable, freq_mode, fetch_flush;
    logic [31:0] freq_addr, freq_wdata;
    logic [3:0]  freq_wstrb;
    logic        fetch_response_enable;
    logic [31:0] fresp_data;
    logic        mem_request_enable, mreq_mode;
    logic [31:0] mreq_addr, mreq_wdata;
    logic [3:0]  mreq_wstrb;
    logic        mem_response_enable;
    logic [31:0] mresp_data;
    logic        request_enable, req_mode;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;
    logic        resp_error, protocol_error, busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .fetch_request_enable  (fetch_request_enable),
        .freq_mode             (freq_mode),
        .freq_addr             (freq_addr),
        .freq_wdata            (freq_wdata),
        .freq_wstrb            (freq_wstrb),
        .fetch_flush           (fetch_flush),
        .fetch_response_enable (fetch_response_enable),
        .fresp_data            (fresp_data),
        .mem_request_enable    (mem_request_enable),
        .mreq_mode             (mreq_mode),
        .mreq_addr             (mreq_addr),
        .mreq_wdata            (mreq_wdata),
        .mreq_wstrb            (mreq_wstrb),
        .mem_response_enable   (mem_response_enable),
        .mresp_data            (mresp_data),
        .request_enable        (request_enable),
        .req_mode              (req_mode),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .req_wstrb             (req_wstrb),
        .response_enable       (response_enable),
        .resp_data             (resp_data),
        .resp_error            (resp_error),
        .protocol_error        (protocol_error),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    logic [138:0] dut_outs;
    assign dut_outs = {request_enable, req_mode, req_addr, req_wdata, req_wstrb,
                       fetch_response_enable, fresp_data, mem_response_enable, mresp_data,
                       resp_error, protocol_error, busy};

    // Transaction-level reference: pending slots, one outstanding transaction with owner and age.
    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    bit          md_slot_v [2];
    txn_t        md_slot   [2];
    bit          md_act, md_done, md_own, md_sq, md_terr, md_lastg, md_req_en, md_perr;
    int          md_age;
    logic [31:0] md_rbuf;
    txn_t        md_req;

    task automatic model_edge();
        txn_t in_r   [2];
        bit   pulse  [2];
        bit   busy_r [2];
        bit   acc    [2];
        bit   want   [2];
        int   g;
        in_r[0]   = {freq_mode, freq_addr, freq_wdata, freq_wstrb};
        in_r[1]   = {mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb};
        pulse[0]  = fetch_request_enable;
        pulse[1]  = mem_request_enable;
        md_req_en = 1'b0;
        if (!rstn) begin
            md_slot_v[0] = 0; md_slot_v[1] = 0;
            md_slot[0] = '0; md_slot[1] = '0;
            md_act = 0; md_done = 0; md_own = 0; md_sq = 0; md_terr = 0;
            md_lastg = 1; md_perr = 0; md_age = 0; md_rbuf = '0; md_req = '0;
        end else begin
            busy_r[0] = md_slot_v[0] || (md_act && !md_own && !md_sq);
            busy_r[1] = md_slot_v[1] || (md_act && md_own);
            acc[0]    = pulse[0] && (fetch_flush || !busy_r[0]);
            acc[1]    = pulse[1] && !busy_r[1];
            if ((pulse[0] && !acc[0]) || (pulse[1] && !acc[1])) md_perr = 1;
            want[0] = !md_act && (acc[0] || (md_slot_v[0] && !fetch_flush));
            want[1] = !md_act && (acc[1] || md_slot_v[1]);
            g = -1;
            if (want[0] && want[1]) g = md_lastg ? 0 : 1;
            else if (want[0])       g = 0;
            else if (want[1])       g = 1;
            for (int r = 0; r < 2; r++) begin
                if (g == r) begin
                    md_req       = acc[r] ? in_r[r] : md_slot[r];
                    md_slot_v[r] = 0;
                end else if (acc[r]) begin
                    md_slot_v[r] = 1;
                    md_slot[r]   = in_r[r];
                end else if (r == 0 && fetch_flush) begin
                    md_slot_v[0] = 0;
                end
            end
            if (md_act && md_done) begin
                md_act  = 0;
                md_done = 0;
            end else if (md_act) begin
                if (fetch_flush && !md_own) md_sq = 1;
                if (response_enable) begin
                    md_rbuf = resp_data; md_terr = 0; md_done = 1;
                end else if (md_age == TMO - 1) begin
                    md_rbuf = '0; md_terr = 1; md_done = 1;
                end
                md_age++;
            end
            if (g >= 0) begin
                md_act = 1; md_done = 0; md_own = (g == 1); md_sq = 0;
                md_age = 0; md_lastg = (g == 1); md_req_en = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_request_enable = 0; freq_mode = 0; freq_addr = '0; freq_wdata = '0; freq_wstrb = '0;
        fetch_flush = 0;
        mem_request_enable = 0; mreq_mode = 0; mreq_addr = '0; mreq_wdata = '0; mreq_wstrb = '0;
        response_enable = 0; resp_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        step();
        rstn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 0;
        step();
        step();
        n_tests++;
        if (dut_outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_outs);
        end
        rstn = 1;
        step();
        n_tests++;
        if (busy !== 1'b0 || request_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b req_en=%b want 0 0", busy, request_enable);
        end
    endtask

    task automatic test_single_fetch();
        int mem_seen = 0;
        do_reset();
        fetch_request_enable = 1; freq_addr = 32'h100; freq_wstrb = 4'hF;
        step();
        idle_inputs();
        n_tests++;
        if (request_enable !== 1'b1 || req_addr !== 32'h100 || req_mode !== 1'b0 || req_wstrb !== 4'hF) begin
            n_fail++; $display("FAIL fetch_grant: req_en=%b addr=%h mode=%b wstrb=%h want 1 100 0 f",
                               request_enable, req_addr, req_mode, req_wstrb);
        end
        step();
        n_tests++;
        if (request_enable !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fetch_pulse_width: req_en=%b busy=%b want 0 1", request_enable, busy);
        end
        response_enable = 1; resp_data = 32'hCAFEBABE;
        step();
        idle_inputs();
        if (mem_response_enable !== 1'b0) mem_seen++;
        n_tests++;
        if (fetch_response_enable !== 1'b1 || fresp_data !== 32'hCAFEBABE || resp_error !== 1'b0) begin
            n_fail++; $display("FAIL fetch_response: en=%b data=%h err=%b want 1 cafebabe 0",
                               fetch_response_enable, fresp_data, resp_error);
        end
        step();
        if (mem_response_enable !== 1'b0) mem_seen++;
        n_tests++;
        if (fetch_response_enable !== 1'b0 || busy !== 1'b0 || req_addr !== 32'h100 || mem_seen != 0) begin
            n_fail++; $display("FAIL fetch_done: fen=%b busy=%b addr=%h mem_rsp=%0d want 0 0 100 0",
                               fetch_response_enable, busy, req_addr, mem_seen);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        fetch_request_enable = 1; freq_addr = 32'h1000; freq_wstrb = 4'hF;
        mem_request_enable = 1; mreq_mode = 1; mreq_addr = 32'h2000; mreq_wdata = 32'hDEADBEEF; mreq_wstrb = 4'h3;
        step();
        idle_inputs();
        n_tests++;
        if (request_enable !== 1'b1 || req_addr !== 32'h1000) begin
            n_fail++; $display("FAIL rr_first_fetch: req_en=%b addr=%h want 1 1000", request_enable, req_addr);
        end
        response_enable = 1; resp_data = 32'h11;
        step();
        idle_inputs();
        n_tests++;
        if (fetch_response_enable !== 1'b1 || fresp_data !== 32'h11 || mem_response_enable !== 1'b0) begin
            n_fail++; $display("FAIL rr_fetch_resp: fen=%b data=%h men=%b want 1 11 0",
                               fetch_response_enable, fresp_data, mem_response_enable);
        end
        step();
        n_tests++;
        if (request_enable !== 1'b0) begin
            n_fail++; $display("FAIL rr_spacing: req_en=%b want 0", request_enable);
        end
        step();
        n_tests++;
        if (request_enable !== 1'b1 || req_addr !== 32'h2000 || req_mode !== 1'b1 ||
            req_wdata !== 32'hDEADBEEF || req_wstrb !== 4'h3) begin
            n_fail++; $display("FAIL rr_mem_grant: req_en=%b addr=%h mode=%b wdata=%h wstrb=%h want 1 2000 1 deadbeef 3",
                               request_enable, req_addr, req_mode, req_wdata, req_wstrb);
        end
        response_enable = 1; resp_data = 32'h22;
        step();
        idle_inputs();
        n_tests++;
        if (mem_response_enable !== 1'b1 || mresp_data !== 32'h22 || fetch_response_enable !== 1'b0) begin
            n_fail++; $display("FAIL rr_mem_resp: men=%b data=%h fen=%b want 1 22 0",
                               mem_response_enable, mresp_data, fetch_response_enable);
        end
        step();
        // A lone fetch makes fetch the last grant, so the next tie goes to mem.
        fetch_request_enable = 1; freq_addr = 32'h1004;
        step();
        idle_inputs();
        response_enable = 1; resp_data = 32'h33;
        step();
        idle_inputs();
        step();
        fetch_request_enable = 1; freq_addr = 32'h1008;
        mem_request_enable = 1; mreq_addr = 32'h2008;
        step();
        idle_inputs();
        n_tests++;
        if (request_enable !== 1'b1 || req_addr !== 32'h2008) begin
            n_fail++; $display("FAIL rr_mem_wins_tie: req_en=%b addr=%h want 1 2008", request_enable, req_addr);
        end
        response_enable = 1; resp_data = 32'h44;
        step();
        idle_inputs();
        step();
        step();
        n_tests++;
        if (request_enable !== 1'b1 || req_addr !== 32'h1008) begin
            n_fail++; $display("FAIL rr_fetch_second: req_en=%b addr=%h want 1 1008", request_enable, req_addr);
        end
        response_enable = 1;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_flush();
        do_reset();
        fetch_request_enable = 1; freq_addr = 32'h500;
        step();
        idle_inputs();
        fetch_flush = 1;
        step();
        idle_inputs();
        response_enable = 1; resp_data = 32'h1234;
        step();
        idle_inputs();
        n_tests++;
        if (fetch_response_enable !== 1'b0 || mem_response_enable !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_squash: fen=%b men=%b busy=%b want 0 0 1",
                               fetch_response_enable, mem_response_enable, busy);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || fetch_response_enable !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: busy=%b fen=%b want 0 0", busy, fetch_response_enable);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_request_enable = 1; mreq_addr = 32'h3000;
        step();
        idle_inputs();
        for (int i = 1; i <= int'(TMO); i++) begin
            n_tests++;
            if (mem_response_enable !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL timeout_wait_c%0d: men=%b busy=%b want 0 1", i, mem_response_enable, busy);
            end
            step();
        end
        n_tests++;
        if (mem_response_enable !== 1'b1 || resp_error !== 1'b1 || mresp_data !== 32'h0) begin
            n_fail++; $display("FAIL timeout_resp: men=%b err=%b data=%h want 1 1 0",
                               mem_response_enable, resp_error, mresp_data);
        end
        step();
        response_enable = 1; resp_data = 32'h9999;
        step();
        idle_inputs();
        step();
        n_tests++;
        if (mem_response_enable !== 1'b0 || resp_error !== 1'b0 || busy !== 1'b0 || request_enable !== 1'b0) begin
            n_fail++; $display("FAIL timeout_late_resp: men=%b err=%b busy=%b req_en=%b want 0 0 0 0",
                               mem_response_enable, resp_error, busy, request_enable);
        end
    endtask

    task automatic test_protocol_error();
        int rsp_cnt = 0;
        int req_cnt = 0;
        do_reset();
        mem_request_enable = 1; mreq_addr = 32'h3000;
        step();
        n_tests++;
        if (protocol_error !== 1'b0) begin
            n_fail++; $display("FAIL perr_initial: got %b want 0", protocol_error);
        end
        mreq_addr = 32'h3004;
        step();
        idle_inputs();
        n_tests++;
        if (protocol_error !== 1'b1) begin
            n_fail++; $display("FAIL perr_set: got %b want 1", protocol_error);
        end
        response_enable = 1; resp_data = 32'h55;
        for (int i = 0; i < 10; i++) begin
            step();
            idle_inputs();
            if (mem_response_enable === 1'b1) rsp_cnt++;
            if (request_enable === 1'b1) req_cnt++;
        end
        n_tests++;
        if (rsp_cnt != 1 || req_cnt != 0 || protocol_error !== 1'b1) begin
            n_fail++; $display("FAIL perr_dropped: responses=%0d grants=%0d perr=%b want 1 0 1",
                               rsp_cnt, req_cnt, protocol_error);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_request_enable = 1; freq_addr = 32'h4000; freq_wdata = 32'hABCD; freq_wstrb = 4'h5;
        step();
        idle_inputs();
        rstn = 0;
        step();
        n_tests++;
        if (dut_outs !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %h want 0", dut_outs);
        end
        rstn = 1;
        response_enable = 1; resp_data = 32'h77;
        step();
        idle_inputs();
        n_tests++;
        if (fetch_response_enable !== 1'b0 || mem_response_enable !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_stray: fen=%b men=%b busy=%b want 0 0 0",
                               fetch_response_enable, mem_response_enable, busy);
        end
        step();
        n_tests++;
        if (fetch_response_enable !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_after: fen=%b busy=%b want 0 0", fetch_response_enable, busy);
        end
    endtask

    task automatic test_random();
        logic [138:0] exp;
        bit           efr, emr;
        for (int c = 0; c < 3000; c++) begin
            rstn                 = (c < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
            fetch_request_enable = ($urandom_range(0, 3) == 0);
            freq_mode            = 1'($urandom);
            freq_addr            = $urandom;
            freq_wdata           = $urandom;
            freq_wstrb           = 4'($urandom);
            fetch_flush          = ($urandom_range(0, 11) == 0);
            mem_request_enable   = ($urandom_range(0, 3) == 0);
            mreq_mode            = 1'($urandom);
            mreq_addr            = $urandom;
            mreq_wdata           = $urandom;
            mreq_wstrb           = 4'($urandom);
            response_enable      = ($urandom_range(0, 2) == 0);
            resp_data            = $urandom;
            @(posedge clk);
            model_edge();
            #1;
            efr = md_act && md_done && !md_own && !md_sq;
            emr = md_act && md_done && md_own;
            exp = {md_req_en, md_req, efr, efr ? md_rbuf : 32'h0, emr, emr ? md_rbuf : 32'h0,
                   md_terr && (efr || emr), md_perr, md_act};
            n_tests++;
            if (dut_outs !== exp) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %h want %h", c, dut_outs, exp);
            end
        end
        idle_inputs();
        rstn = 1;
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_flush();
        test_timeout();
        test_protocol_error();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
